// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - decode/execute observation and hazard control bundle
//
// Signals:
//   id_rs1, id_rs2         source registers of the instruction in ID
//   id_rs1_en, id_rs2_en   ID instruction actually reads rs1 / rs2
//   ex_rd                  destination register of the instruction in EX
//   ex_load                EX instruction is a load
//   ex_br_taken            EX resolved a taken branch or jump
//   ex_mdu                 EX instruction is a multi-cycle mul/div
//   pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_flush
//                          pipeline register controls from the controller
//   mdu_busy               controller is sequencing a mul/div
//   stall_cnt              saturating count of PC-hold cycles
// Modports: master = pipeline side, slave = hazard controller.
interface pipe_hazard_ctrl_if;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_rs1_en;
  logic        id_rs2_en;
  logic [4:0]  ex_rd;
  logic        ex_load;
  logic        ex_br_taken;
  logic        ex_mdu;
  logic        pc_hold;
  logic        if_id_hold;
  logic        if_id_flush;
  logic        id_ex_hold;
  logic        id_ex_flush;
  logic        ex_mem_flush;
  logic        mdu_busy;
  logic [15:0] stall_cnt;

  modport master (
    output id_rs1, id_rs2, id_rs1_en, id_rs2_en, ex_rd, ex_load, ex_br_taken, ex_mdu,
    input  pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_flush,
           mdu_busy, stall_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_en, id_rs2_en, ex_rd, ex_load, ex_br_taken, ex_mdu,
    output pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_flush,
           mdu_busy, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - load-use, branch and mul/div hazard controller for a 5-stage pipeline
//
// Ports:
//   clk   pipeline clock, rising edge
//   rst   synchronous active-low reset
//   hz    pipe_hazard_ctrl_if.slave: ID/EX observations in, hold/flush controls,
//         mdu_busy and stall_cnt out
// Parameter MDU_LAT (2..16): total EX residency of a mul/div instruction.
// Build macro PIPE_CTRL_MDU_EN: when defined, mul/div sequencing (MDU state) is
// present; when undefined, ex_mdu is ignored and id_ex_hold/ex_mem_flush/mdu_busy are 0.
module pipe_hazard_ctrl #(
  parameter int MDU_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  pipe_hazard_ctrl_if.slave hz
);

  logic        load_use;
  logic [15:0] stall_q;

  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use = hz.ex_load && (hz.ex_rd != 5'd0) &&
                    ((hz.id_rs1_en && (hz.id_rs1 == hz.ex_rd)) ||
                     (hz.id_rs2_en && (hz.id_rs2 == hz.ex_rd)));

`ifdef PIPE_CTRL_MDU_EN
  typedef enum logic {RUN = 1'b0, MDU = 1'b1} state_t;

  // Entry cycle happens in RUN and the release cycle has cnt==0, so the
  // counter only covers the held cycles in between.
  localparam logic [3:0] CNT_INIT = 4'(MDU_LAT - 2);

  state_t     state;
  logic [3:0] cnt;

  always_comb begin
    hz.pc_hold      = 1'b0;
    hz.if_id_hold   = 1'b0;
    hz.if_id_flush  = 1'b0;
    hz.id_ex_hold   = 1'b0;
    hz.id_ex_flush  = 1'b0;
    hz.ex_mem_flush = 1'b0;
    hz.mdu_busy     = 1'b0;
    if (rst) begin
      if (state == MDU) begin
        hz.mdu_busy = 1'b1;
        if (cnt != 4'd0) begin
          hz.pc_hold      = 1'b1;
          hz.if_id_hold   = 1'b1;
          hz.id_ex_hold   = 1'b1;
          hz.ex_mem_flush = 1'b1;
        end
      end else if (hz.ex_br_taken) begin
        hz.if_id_flush = 1'b1;
        hz.id_ex_flush = 1'b1;
      end else if (hz.ex_mdu) begin
        hz.pc_hold      = 1'b1;
        hz.if_id_hold   = 1'b1;
        hz.id_ex_hold   = 1'b1;
        hz.ex_mem_flush = 1'b1;
      end else if (load_use) begin
        hz.pc_hold     = 1'b1;
        hz.if_id_hold  = 1'b1;
        hz.id_ex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      case (state)
        RUN: begin
          if (!hz.ex_br_taken && hz.ex_mdu) begin
            state <= MDU;
            cnt   <= CNT_INIT;
          end
        end
        MDU: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end
`else
  logic unused_mdu;
  assign unused_mdu = hz.ex_mdu ^ 1'(MDU_LAT);

  always_comb begin
    hz.pc_hold      = 1'b0;
    hz.if_id_hold   = 1'b0;
    hz.if_id_flush  = 1'b0;
    hz.id_ex_hold   = 1'b0;
    hz.id_ex_flush  = 1'b0;
    hz.ex_mem_flush = 1'b0;
    hz.mdu_busy     = 1'b0;
    if (rst) begin
      if (hz.ex_br_taken) begin
        hz.if_id_flush = 1'b1;
        hz.id_ex_flush = 1'b1;
      end else if (load_use) begin
        hz.pc_hold     = 1'b1;
        hz.if_id_hold  = 1'b1;
        hz.id_ex_flush = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q <= 16'd0;
    end else if (hz.pc_hold && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign hz.stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - randomized and directed checks of pipe_hazard_ctrl against a behavioural model
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] s_rs1 = '0, s_rs2 = '0, s_rd = '0;
  logic       s_rs1_en = 0, s_rs2_en = 0, s_load = 0, s_br = 0, s_mdu = 0;

  int tests = 0;
  int fails = 0;

  pipe_hazard_ctrl_if if4();
  pipe_hazard_ctrl_if if2();

  assign if4.id_rs1 = s_rs1;       assign if2.id_rs1 = s_rs1;
  assign if4.id_rs2 = s_rs2;       assign if2.id_rs2 = s_rs2;
  assign if4.id_rs1_en = s_rs1_en; assign if2.id_rs1_en = s_rs1_en;
  assign if4.id_rs2_en = s_rs2_en; assign if2.id_rs2_en = s_rs2_en;
  assign if4.ex_rd = s_rd;         assign if2.ex_rd = s_rd;
  assign if4.ex_load = s_load;     assign if2.ex_load = s_load;
  assign if4.ex_br_taken = s_br;   assign if2.ex_br_taken = s_br;
  assign if4.ex_mdu = s_mdu;       assign if2.ex_mdu = s_mdu;

  pipe_hazard_ctrl #(.MDU_LAT(4)) dut4 (.clk(clk), .rst(rst), .hz(if4.slave));
  pipe_hazard_ctrl #(.MDU_LAT(2)) dut2 (.clk(clk), .rst(rst), .hz(if2.slave));

`ifdef PIPE_CTRL_MDU_EN
  localparam bit MDU_EN = 1'b1;
`else
  localparam bit MDU_EN = 1'b0;
`endif

  // Model state: cycles of MDU residency still to come (0 = running normally).
  int          left4 = 0, left2 = 0;
  logic [15:0] sc4 = '0, sc2 = '0;
  bit          mvalid = 1'b0;

  function automatic bit lu_hit();
    return s_load && (s_rd != 0) &&
           ((s_rs1_en && s_rs1 == s_rd) || (s_rs2_en && s_rs2 == s_rd));
  endfunction

  // Bit order: pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_flush, mdu_busy
  function automatic logic [6:0] exp_ctl(input int left);
    logic [6:0] e;
    e = '0;
    if (!rst) return e;
    if (MDU_EN && left > 0) e = (left > 1) ? 7'b1101011 : 7'b0000001;
    else if (s_br) e = 7'b0010100;
    else if (MDU_EN && s_mdu) e = 7'b1101010;
    else if (lu_hit()) e = 7'b1100100;
    return e;
  endfunction

  function automatic int next_left(input int left, input int lat);
    if (left > 0) return left - 1;
    if (MDU_EN && s_mdu && !s_br) return lat - 1;
    return 0;
  endfunction

  function automatic logic [15:0] next_sc(input logic [15:0] sc, input int left);
    logic [6:0] e;
    e = exp_ctl(left);
    if (e[6] && sc != 16'hFFFF) return sc + 16'd1;
    return sc;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      left4 <= 0; left2 <= 0; sc4 <= '0; sc2 <= '0; mvalid <= 1'b1;
    end else begin
      left4 <= next_left(left4, 4);
      left2 <= next_left(left2, 2);
      sc4   <= next_sc(sc4, left4);
      sc2   <= next_sc(sc2, left2);
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mvalid) begin
      check("ctl_lat4", 16'({if4.pc_hold, if4.if_id_hold, if4.if_id_flush, if4.id_ex_hold,
                             if4.id_ex_flush, if4.ex_mem_flush, if4.mdu_busy}), 16'(exp_ctl(left4)));
      check("cnt_lat4", if4.stall_cnt, sc4);
      check("ctl_lat2", 16'({if2.pc_hold, if2.if_id_hold, if2.if_id_flush, if2.id_ex_hold,
                             if2.id_ex_flush, if2.ex_mem_flush, if2.mdu_busy}), 16'(exp_ctl(left2)));
      check("cnt_lat2", if2.stall_cnt, sc2);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    s_rs1 = 0; s_rs2 = 0; s_rd = 0; s_rs1_en = 0; s_rs2_en = 0;
    s_load = 0; s_br = 0; s_mdu = 0;
  endtask

  task automatic set_lu(input logic [4:0] rd);
    clear_in();
    s_load = 1; s_rd = rd; s_rs2_en = 1; s_rs2 = rd;
  endtask

  initial begin
    clear_in();
    rst = 0;
    step(); step();
    rst = 1;
    @(negedge clk);
    check("reset_stall_cnt", if4.stall_cnt, 16'd0);
    check("reset_busy", 16'(if4.mdu_busy), 16'd0);
    step();

    // Load-use on x5 stalls once.
    set_lu(5'd5);
    @(negedge clk);
    check("lu_pc_hold", 16'(if4.pc_hold), 16'd1);
    check("lu_if_id_hold", 16'(if4.if_id_hold), 16'd1);
    check("lu_id_ex_flush", 16'(if4.id_ex_flush), 16'd1);
    step();
    clear_in();
    @(negedge clk);
    check("lu_stall_cnt", if4.stall_cnt, 16'd1);
    step();

    // Load to x0 never stalls.
    set_lu(5'd0);
    @(negedge clk);
    check("x0_pc_hold", 16'(if4.pc_hold), 16'd0);
    step();

    // Branch beats load-use.
    set_lu(5'd7);
    s_br = 1;
    @(negedge clk);
    check("br_if_id_flush", 16'(if4.if_id_flush), 16'd1);
    check("br_id_ex_flush", 16'(if4.id_ex_flush), 16'd1);
    check("br_pc_hold", 16'(if4.pc_hold), 16'd0);
    step();
    clear_in();
    @(negedge clk);
    check("br_stall_cnt", if4.stall_cnt, 16'd1);
    step();

    // Mul/div sequencing, cycles 0..3 after issue.
    s_mdu = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("mdu4_hold", 16'(if4.pc_hold & if4.id_ex_hold & if4.ex_mem_flush),
            16'(MDU_EN && c <= 2));
      check("mdu4_busy", 16'(if4.mdu_busy), 16'(MDU_EN && c >= 1));
      check("mdu2_hold", 16'(if2.pc_hold | if2.id_ex_hold), 16'(MDU_EN && c == 0));
      check("mdu2_busy", 16'(if2.mdu_busy), 16'(MDU_EN && c == 1));
      step();
      s_mdu = 0;
    end
    @(negedge clk);
    check("mdu4_stall_cnt", if4.stall_cnt, MDU_EN ? 16'd4 : 16'd1);
    check("mdu2_stall_cnt", if2.stall_cnt, MDU_EN ? 16'd2 : 16'd1);
    step();

    // Reset in the second MDU cycle aborts the sequence.
    s_mdu = 1;
    step();
    s_mdu = 0;
    rst = 0;
    @(negedge clk);
    check("rst_mdu_hold", 16'(if4.pc_hold | if4.ex_mem_flush), 16'd0);
    check("rst_mdu_busy", 16'(if4.mdu_busy), 16'd0);
    step();
    rst = 1;
    @(negedge clk);
    check("post_rst_busy", 16'(if4.mdu_busy), 16'd0);
    check("post_rst_stall_cnt", if4.stall_cnt, 16'd0);
    step();

    // Saturation under a persistent load-use hit.
    set_lu(5'd9);
    repeat (70000) step();
    @(negedge clk);
    check("sat_stall_cnt", if4.stall_cnt, 16'hFFFF);
    step();
    clear_in();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 63) != 0);
      s_rs1    = 5'($urandom_range(0, 3));
      s_rs2    = 5'($urandom_range(0, 3));
      s_rd     = 5'($urandom_range(0, 3));
      s_rs1_en = 1'($urandom_range(0, 1));
      s_rs2_en = 1'($urandom_range(0, 1));
      s_load   = 1'($urandom_range(0, 1));
      s_br     = ($urandom_range(0, 5) == 0);
      s_mdu    = ($urandom_range(0, 7) == 0);
      step();
    end
    rst = 1;
    clear_in();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and sequencing controller for the 5-stage RISC-V pipeline. It watches the decode and execute stages and drives hold/flush controls for the PC, IF/ID, ID/EX and EX/MEM registers. It resolves load-use hazards, taken-branch redirects and multi-cycle mul/div occupancy of EX. It also keeps a saturating stall-cycle counter for performance monitoring.

## Interface
Parameters:
- MDU_LAT, 4, total cycles a mul/div instruction occupies EX; legal range 2..16.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  reset; one clock; reset is synchronous and active-low
- id_rs1  in  5  source register 1 of the instruction in ID
- id_rs2  in  5  source register 2 of the instruction in ID
- id_rs1_en  in  1  ID instruction reads rs1
- id_rs2_en  in  1  ID instruction reads rs2
- ex_rd  in  5  destination register of the instruction in EX
- ex_load  in  1  EX instruction is a load
- ex_br_taken  in  1  EX resolved a taken branch or jump this cycle
- ex_mdu  in  1  EX instruction is a multi-cycle mul/div
- pc_hold  out  1  PC keeps its value
- if_id_hold  out  1  IF/ID keeps its contents
- if_id_flush  out  1  IF/ID loads a bubble
- id_ex_hold  out  1  ID/EX keeps its contents
- id_ex_flush  out  1  ID/EX loads a bubble (all-zero ctl/msg)
- ex_mem_flush  out  1  EX/MEM loads a bubble
- mdu_busy  out  1  controller is in MDU state
- stall_cnt  out  16  saturating count of cycles with pc_hold=1

## Operation
- States: RUN, MDU. Internal 4-bit down-counter cnt.
- Load-use hit: ex_load && ex_rd!=0 && ((id_rs1_en && id_rs1==ex_rd) || (id_rs2_en && id_rs2==ex_rd)).
- RUN priority, highest first:
  - ex_br_taken=1 -> if_id_flush=1, id_ex_flush=1; all holds 0; load-use and ex_mdu are ignored.
  - ex_mdu=1 -> pc_hold, if_id_hold and id_ex_hold =1; ex_mem_flush=1; cnt<=MDU_LAT-2; next state MDU.
  - Load-use hit -> pc_hold=1, if_id_hold=1, id_ex_flush=1; state stays RUN. The bubble clears the hazard next cycle.
  - Otherwise all control outputs are 0.
- MDU state: mdu_busy=1; ex_br_taken and load-use are ignored.
  - cnt!=0 -> all three holds =1, ex_mem_flush=1, cnt<=cnt-1.
  - cnt==0 -> release cycle: all outputs 0 (the result enters EX/MEM); next state RUN.
- EX residency of a mul/div is exactly MDU_LAT cycles: the entry cycle, MDU_LAT-2 held cycles, then the release cycle.
- stall_cnt increments on every cycle with pc_hold=1 and saturates at 16'hFFFF.
- Register x0 never causes a load-use stall.

## Timing
- Control outputs are combinational from inputs, state and cnt. They take effect at the next rising edge of clk.
- Load-use costs exactly 1 stall cycle; a taken branch costs 2 flushed slots; a mul/div costs MDU_LAT-1 stall cycles.
- Back-to-back mul/div: the release cycle is followed by RUN. A new ex_mdu in that next cycle re-enters MDU.
- Reset (rst=0 sampled at an edge): state<=RUN, cnt<=0, stall_cnt<=0.
  - While rst=0, all control outputs and mdu_busy are forced to 0.
  - Reset during MDU aborts the sequence; the first cycle after reset is RUN.
- MDU_LAT outside 2..16 is illegal and unsupported.

## Configuration
- PIPE_CTRL_MDU_EN defined: MDU state, cnt and id_ex_hold behave as described above.
- PIPE_CTRL_MDU_EN undefined:
  - ex_mdu is ignored and the state is permanently RUN.
  - id_ex_hold, ex_mem_flush and mdu_busy are tied to 0.
  - MDU_LAT is unused.
  - Load-use, branch handling and stall_cnt are unchanged.

## Test plan
- Load-use: ex_load=1, ex_rd=5, id_rs2_en=1, id_rs2=5 for one cycle -> pc_hold, if_id_hold and id_ex_flush =1 that cycle; stall_cnt=1 afterwards. Same stimulus with ex_rd=0 -> no stall.
- Branch priority: ex_br_taken=1 together with a load-use hit -> if_id_flush=1, id_ex_flush=1, pc_hold=0; stall_cnt unchanged.
- MDU, MDU_LAT=4: ex_mdu=1 at cycle 0 -> holds and ex_mem_flush =1 in cycles 0-2 and all 0 in cycle 3; mdu_busy=1 in cycles 1-3; stall_cnt=3. Repeat with MDU_LAT=2 -> exactly one held cycle.
- Reset mid-MDU: rst=0 in the second MDU cycle -> outputs 0 during reset; mdu_busy=0 and stall_cnt=0 after reset.
- Saturation: hold a load-use hit for 70000 cycles -> stall_cnt=16'hFFFF and does not wrap.
- Build without PIPE_CTRL_MDU_EN: ex_mdu=1 -> all outputs 0 and mdu_busy=0.
